rb_write_arbiter: RTL and testbench

//  Round-robin write-side arbiter that shares one ringbuffer FIFO among NUM_REQ producers.

---
 rtl/rb_write_arbiter_pkg.sv | 21 ++
 rtl/rb_write_arbiter_if.sv | 37 +++
 rtl/rb_write_arbiter_rr_pick.sv | 36 +++
 rtl/rb_write_arbiter.sv | 105 ++++++++++
 tb/tb_rb_write_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rb_write_arbiter_pkg.sv
// Shared definitions for the ringbuffer write-side arbiter.
// Holds the FSM state type, the default word width and ringbuffer depth
// shared with the ringbuffer, and a small index-wrap helper.
package rb_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned MAX_BURST = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // Increment an index modulo n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/rb_write_arbiter_if.sv
// Producer/FIFO-write bundle of the ringbuffer write arbiter.
//  req       producer i has a valid word
//  req_data  word of producer i at [i*DATA_W +: DATA_W]
//  req_last  current word of producer i ends its packet
//  gnt       one-hot; word of producer i accepted this cycle
//  fifo_full ringbuffer full flag
//  fifo_wr_en/fifo_data  ringbuffer write port
//  owner/busy            current owner index, 1 while a producer owns the port
// master: producers + FIFO side; slave: the arbiter.
interface rb_write_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = rb_pkg::DATA_W
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        gnt;
    logic                      fifo_full;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_data;
    logic [IDX_W-1:0]          owner;
    logic                      busy;

    modport master (
        output req, req_data, req_last, fifo_full,
        input  gnt, fifo_wr_en, fifo_data, owner, busy
    );

    modport slave (
        input  req, req_data, req_last, fifo_full,
        output gnt, fifo_wr_en, fifo_data, owner, busy
    );

endinterface

// File: rtl/rb_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
//  req     request vector
//  rr_ptr  index with highest priority
//  idx     first requesting index at or after rr_ptr (modulo NUM_REQ)
//  found   1 when any request is set
module rr_pick #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    int unsigned      sum;
    logic [IDX_W-1:0] cand;

    // Walk the offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx   = rr_ptr;
        found = 1'b0;
        sum   = 32'd0;
        cand  = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            sum  = 32'(rr_ptr) + 32'(k);
            sum  = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
            cand = IDX_W'(sum);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rb_write_arbiter.sv
// Round-robin write-side arbiter sharing one ringbuffer among NUM_REQ producers.
// A producer owns the FIFO write port for up to MAX_BURST accepted words or
// until its last word, then ownership rotates through one IDLE bubble cycle.
//  clk  rising-edge clock
//  rst  synchronous active-low reset
//  bus  producer request/grant lines and FIFO write port (slave side)
module rb_write_arbiter
    import rb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = rb_pkg::DATA_W,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    rb_write_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic              accept;
    logic              burst_end;
    logic [DATA_W-1:0] data_sel;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr_q),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    // A word moves only while owning, the owner presents it and the FIFO has room.
    assign accept    = (state_q == ST_OWN) && bus.req[owner_q] && !bus.fifo_full;
    assign burst_end = accept && (bus.req_last[owner_q] || (cnt_q == CNT_W'(MAX_BURST - 1)));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic: pick in IDLE, count and release in OWN.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = ST_OWN;
                end
            end
            ST_OWN: begin
                // Withdrawal releases even when the FIFO is full.
                if (!bus.req[owner_q] || burst_end) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = IDX_W'(wrap_inc(32'(owner_q), NUM_REQ));
                end else if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Owner's word select.
    always_comb begin
        data_sel = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (owner_q == IDX_W'(i)) begin
                data_sel = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Zero-latency write path into the ringbuffer.
    assign bus.gnt        = accept ? (NUM_REQ'(1) << owner_q) : '0;
    assign bus.fifo_wr_en = accept;
    assign bus.fifo_data  = accept ? data_sel : '0;
    assign bus.owner      = owner_q;
    assign bus.busy       = (state_q == ST_OWN);

endmodule

// File: tb/tb_rb_write_arbiter.sv
// Testbench for rb_write_arbiter with a behavioural ringbuffer occupancy model.
module tb_rb_write_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int MB    = 4;
    localparam int DEPTH = rb_pkg::DEPTH;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } word_t;

    typedef struct {
        logic         skip;
        logic [N-1:0] gnt;
        logic         busy;
        int           owner;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rb_write_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

    rb_write_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (W),
        .MAX_BURST (MB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    word_t        pq [N][$];
    logic [N-1:0] pause      = '0;
    logic         s_rst      = 1'b0;
    logic         force_full = 1'b0;
    logic         drain      = 1'b1;
    int           occ        = 0;
    bit           first_cycle = 1'b1;

    // Reference model of the arbitration rules.
    int m_busy  = 0;
    int m_owner = 0;
    int m_cnt   = 0;
    int m_ptr   = 0;

    exp_t         cyc_q[$];
    logic [W-1:0] wr_q[$];
    int           glog[$];
    int           dlog[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: logs grants and compares against the scoreboard each cycle.
    always @(negedge clk) begin
        int   gi;
        exp_t e;
        gi = -1;
        for (int i = 0; i < N; i++)
            if (bus.gnt[i] === 1'b1 && bus.fifo_wr_en === 1'b1) gi = i;
        glog.push_back(gi);
        if (bus.fifo_wr_en === 1'b1) dlog.push_back(int'(bus.fifo_data));
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            if (!e.skip) begin
                check("gnt", 32'(bus.gnt), 32'(e.gnt));
                check("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(|e.gnt));
                check("busy", 32'(bus.busy), 32'(e.busy));
                if (e.busy) check("owner", 32'(bus.owner), 32'(e.owner));
                check("no_write_when_full", 32'(bus.fifo_wr_en & bus.fifo_full), 32'd0);
                if (bus.fifo_wr_en === 1'b1) begin
                    if (wr_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: got data %0h, expected no write (t=%0t)",
                                 bus.fifo_data, $time);
                    end else begin
                        check("fifo_data", 32'(bus.fifo_data), 32'(wr_q.pop_front()));
                    end
                end else begin
                    check("fifo_data_idle", 32'(bus.fifo_data), 32'd0);
                end
            end
        end
    end

    // One clock of stimulus plus the reference model's prediction for it.
    task automatic tick();
        logic [N-1:0]   rv, lv, g;
        logic [N*W-1:0] dv;
        logic           full, acc;
        exp_t           e;
        int             o;
        @(posedge clk);
        #1;
        full = force_full || (occ >= DEPTH);
        rv = '0; lv = '0; dv = '0;
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0) begin
                rv[i] = !pause[i];
                lv[i] = pq[i][0].l;
                dv[i*W +: W] = pq[i][0].d;
            end
        end
        bus.req       = rv;
        bus.req_last  = lv;
        bus.req_data  = dv;
        bus.fifo_full = full;
        rst           = s_rst;
        #1;
        g   = '0;
        acc = 1'b0;
        o   = m_owner;
        if (m_busy != 0) begin
            acc = rv[o] && !full;
            if (acc) g[o] = 1'b1;
        end
        e.skip  = first_cycle;
        e.gnt   = g;
        e.busy  = (m_busy != 0);
        e.owner = m_owner;
        cyc_q.push_back(e);
        first_cycle = 1'b0;
        if (acc) wr_q.push_back(pq[o][0].d);
        if (!s_rst) begin
            m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; occ = 0;
        end else begin
            if (m_busy == 0) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (rv[c]) begin
                        m_owner = c; m_busy = 1; m_cnt = 0;
                        break;
                    end
                end
            end else if (!rv[o] || (acc && (lv[o] || m_cnt == MB - 1))) begin
                m_busy = 0;
                m_ptr  = (o + 1) % N;
            end else if (acc) begin
                m_cnt++;
            end
            occ = occ + (acc ? 1 : 0) - ((drain && occ > 0) ? 1 : 0);
        end
        if (acc) pq[o].delete(0);
    endtask

    task automatic load(input int p, input int n, input logic [W-1:0] base, input logic last_end);
        word_t w;
        for (int k = 0; k < n; k++) begin
            w.d = base + W'(k);
            w.l = last_end && (k == n - 1);
            pq[p].push_back(w);
        end
    endtask

    task automatic clear_queues();
        for (int i = 0; i < N; i++) pq[i].delete();
        pause      = '0;
        force_full = 1'b0;
        drain      = 1'b1;
    endtask

    task automatic flush_reset();
        clear_queues();
        s_rst = 1'b0;
        tick();
        s_rst = 1'b1;
    endtask

    task automatic start_log();
        @(negedge clk);
        #1;
        glog.delete();
        dlog.delete();
    endtask

    task automatic check_q(input string nm, input int act[$], input int ex[$]);
        check({nm, "_len"}, 32'(act.size()), 32'(ex.size()));
        for (int i = 0; i < ex.size() && i < act.size(); i++)
            check(nm, 32'(act[i]), 32'(ex[i]));
    endtask

    initial begin
        int    ex[$];
        word_t w;
        rst           = 1'b0;
        bus.req       = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.fifo_full = 1'b0;

        // Reset held two clocks with every producer requesting.
        s_rst = 1'b0;
        for (int i = 0; i < N; i++) load(i, 1, 8'h11, 1'b0);
        tick();
        tick();
        @(negedge clk);
        #1;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_owner", 32'(bus.owner), 32'd0);
        check("rst_data", 32'(bus.fifo_data), 32'd0);
        clear_queues();
        s_rst = 1'b1;

        // Single packet AA,BB,CC from producer 0.
        start_log();
        w.d = 8'hAA; w.l = 1'b0; pq[0].push_back(w);
        w.d = 8'hBB; w.l = 1'b0; pq[0].push_back(w);
        w.d = 8'hCC; w.l = 1'b1; pq[0].push_back(w);
        repeat (5) tick();
        @(negedge clk);
        #1;
        ex = '{-1, 0, 0, 0, -1};
        check_q("t2_grants", glog, ex);
        ex = '{32'hAA, 32'hBB, 32'hCC};
        check_q("t2_data", dlog, ex);
        check("t2_busy_after", 32'(bus.busy), 32'd0);

        // Two continuous producers rotate in MAX_BURST chunks.
        flush_reset();
        start_log();
        load(0, 12, 8'h10, 1'b0);
        load(2, 12, 8'h20, 1'b0);
        repeat (15) tick();
        @(negedge clk);
        #1;
        ex = '{-1, 0, 0, 0, 0, -1, 2, 2, 2, 2, -1, 0, 0, 0, 0};
        check_q("t3_rotation", glog, ex);

        // FIFO full mid-burst freezes the burst count.
        flush_reset();
        start_log();
        load(1, 8, 8'h40, 1'b0);
        repeat (3) tick();
        force_full = 1'b1;
        repeat (3) tick();
        force_full = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        #1;
        ex = '{-1, 1, 1, -1, -1, -1, 1, 1, -1, 1};
        check_q("t4_full_stall", glog, ex);

        // Reset in the middle of producer 3's burst.
        flush_reset();
        load(3, 8, 8'h50, 1'b0);
        repeat (3) tick();
        load(1, 4, 8'h58, 1'b0);
        s_rst = 1'b0;
        tick();
        s_rst = 1'b1;
        start_log();
        tick();
        @(negedge clk);
        #1;
        check("t5_busy_after_rst", 32'(bus.busy), 32'd0);
        tick();
        @(negedge clk);
        #1;
        ex = '{-1, 1};
        check_q("t5_first_grant", glog, ex);

        // Owner 2 withdraws after one word; producer 0 follows.
        flush_reset();
        load(2, 1, 8'h60, 1'b0);
        start_log();
        tick();
        load(0, 2, 8'h70, 1'b0);
        repeat (4) tick();
        @(negedge clk);
        #1;
        ex = '{-1, 2, -1, -1, 0};
        check_q("t6_withdraw", glog, ex);
        check("t6_owner", 32'(bus.owner), 32'd0);

        // Randomised traffic against the reference model.
        flush_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (pq[i].size() == 0 && $urandom_range(0, 2) == 0) begin
                    int n;
                    n = $urandom_range(1, 6);
                    for (int k = 0; k < n; k++) begin
                        w.d = W'($urandom);
                        w.l = ($urandom_range(0, 3) == 0);
                        pq[i].push_back(w);
                    end
                end
                pause[i] = ($urandom_range(0, 9) == 0);
            end
            force_full = ($urandom_range(0, 7) == 0);
            drain      = ($urandom_range(0, 1) == 1);
            s_rst      = ($urandom_range(0, 299) != 0);
            tick();
        end
        clear_queues();
        s_rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        #1;
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
